// File: rtl/imem_fetch_responder_if.sv
// rtl/imem_fetch_responder_if.sv - fetch and loader signal bundle for imem_fetch_responder
interface imem_fetch_responder_if #(
  parameter int LEN_W = 16
) ();
  logic [31:0]      fetch_addr;
  logic             fetch_en;
  logic [31:0]      fetch_data;
  logic             fetch_fault;
  logic             load_start;
  logic [LEN_W-1:0] load_len;
  logic             load_valid;
  logic [7:0]       load_byte;
  logic             load_ready;
  logic             load_done;
  logic             core_hold;

  modport master (
    output fetch_addr, fetch_en, load_start, load_len, load_valid, load_byte,
    input  fetch_data, fetch_fault, load_ready, load_done, core_hold
  );

  modport slave (
    input  fetch_addr, fetch_en, load_start, load_len, load_valid, load_byte,
    output fetch_data, fetch_fault, load_ready, load_done, core_hold
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - halfword-addressed instruction memory with byte-stream loader
// Optional feature macro: IMEM_RANGE_CHECK_EN (out-of-range fetch returns NOP and raises fetch_fault)
module imem_fetch_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LEN_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_fetch_responder_if.slave bus
);
  localparam int               AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  // Even bank holds the low halfword of each word, odd bank the high halfword.
  logic [15:0] even_mem [DEPTH_WORDS];
  logic [15:0] odd_mem  [DEPTH_WORDS];

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [23:0]      asm_q, asm_d;
  logic             load_ready_q, load_ready_d;
  logic             load_done_q, load_done_d;
  logic             core_hold_q, core_hold_d;
  logic [31:0]      fetch_data_q, fetch_data_d;
  logic             fetch_fault_q, fetch_fault_d;

  logic             wr_en;
  logic [15:0]      wr_lo, wr_hi;
  logic [AW-1:0]    rd_k, rd_k1;
  logic [31:0]      parcel;
  logic             out_of_range;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bus.fetch_addr[31:AW+2], bus.fetch_addr[0]};

  // Loader FSM next-state: assemble bytes into a word, commit on the fourth byte.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    words_d    = words_q;
    byte_cnt_d = byte_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    asm_d      = asm_q;
    wr_en      = 1'b0;
    wr_lo      = asm_q[15:0];
    wr_hi      = {bus.load_byte, asm_q[23:16]};
    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          len_d      = bus.load_len;
          words_d    = '0;
          wr_ptr_d   = '0;
          byte_cnt_d = '0;
          state_d    = (bus.load_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.load_valid && load_ready_q) begin
          case (byte_cnt_q)
            2'd0:    asm_d[7:0]   = bus.load_byte;
            2'd1:    asm_d[15:8]  = bus.load_byte;
            2'd2:    asm_d[23:16] = bus.load_byte;
            default: wr_en        = 1'b1;
          endcase
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            words_d    = words_q + LEN_ONE;
            if (words_d == len_q) state_d = S_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered copies of what the next state implies.
    load_ready_d = (state_d == S_LOAD);
    load_done_d  = (state_d == S_DONE);
    core_hold_d  = (state_d != S_IDLE);
  end

  // Fetch path: pick the two halfwords of the parcel from the banks, NOP while held.
  always_comb begin
    rd_k  = bus.fetch_addr[AW+1:2];
    rd_k1 = rd_k + PTR_ONE;
    if (bus.fetch_addr[1]) parcel = {even_mem[rd_k1], odd_mem[rd_k]};
    else                   parcel = {odd_mem[rd_k], even_mem[rd_k]};
`ifdef IMEM_RANGE_CHECK_EN
    out_of_range = |bus.fetch_addr[31:AW+2];
`else
    out_of_range = 1'b0;
`endif
    fetch_data_d  = fetch_data_q;
    fetch_fault_d = fetch_fault_q;
    if (bus.fetch_en) begin
      fetch_fault_d = out_of_range;
      fetch_data_d  = (core_hold_q || out_of_range) ? NOP : parcel;
    end
  end

  // All control and output state, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      words_q       <= '0;
      byte_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      asm_q         <= '0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      core_hold_q   <= 1'b0;
      fetch_data_q  <= NOP;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      words_q       <= words_d;
      byte_cnt_q    <= byte_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      asm_q         <= asm_d;
      load_ready_q  <= load_ready_d;
      load_done_q   <= load_done_d;
      core_hold_q   <= core_hold_d;
      fetch_data_q  <= fetch_data_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // Bank write: both halves of the assembled word land in the same cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      even_mem[wr_ptr_q] <= wr_lo;
      odd_mem[wr_ptr_q]  <= wr_hi;
    end
  end

  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.load_ready  = load_ready_q;
  assign bus.load_done   = load_done_q;
  assign bus.core_hold   = core_hold_q;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - directed and randomized bench for imem_fetch_responder
module tb_imem_fetch_responder;
  localparam int          DEPTH = 4;
  localparam int          LEN_W = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_fetch_responder_if #(.LEN_W(LEN_W)) bus ();
  imem_fetch_responder #(.DEPTH_WORDS(DEPTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: memory as a flat halfword stream, little-endian within each word.
  logic [31:0] mem_m   [DEPTH];
  bit          known_m [DEPTH];
  logic [31:0] last_d;
  logic        last_f;
  bit          last_ok;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [15:0] hw_m(input int unsigned i);
    int unsigned w;
    w = (i / 2) % DEPTH;
    return (i % 2 == 1) ? mem_m[w][31:16] : mem_m[w][15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input string tag);
    int unsigned h;
    logic [31:0] exp_d;
    logic        exp_f;
    bit          rc;
    h = a >> 1;
`ifdef IMEM_RANGE_CHECK_EN
    rc = 1'b1;
`else
    rc = 1'b0;
`endif
    @(negedge clk);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = a;
    @(posedge clk);
    #1;
    if (rc && a >= 32'(DEPTH * 4)) begin
      exp_d = NOP;
      exp_f = 1'b1;
    end else begin
      if (!(known_m[(h / 2) % DEPTH] && known_m[((h + 1) / 2) % DEPTH])) begin
        last_ok = 1'b0;
        return;
      end
      exp_d = {hw_m(h + 1), hw_m(h)};
      exp_f = 1'b0;
    end
    chk({tag, "_data"}, bus.fetch_data, exp_d);
    chk({tag, "_fault"}, 32'(bus.fetch_fault), 32'(exp_f));
    last_d  = exp_d;
    last_f  = exp_f;
    last_ok = 1'b1;
  endtask

  task automatic stall_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.fetch_en   = 1'b0;
      bus.fetch_addr = $urandom;
      @(posedge clk);
      #1;
      if (last_ok) begin
        chk("stall_data", bus.fetch_data, last_d);
        chk("stall_fault", 32'(bus.fetch_fault), 32'(last_f));
      end
    end
  endtask

  task automatic load_words(input logic [31:0] words [$], input bit gaps);
    int n;
    n = words.size();
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_len   = LEN_W'(n);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = 32'($urandom_range(0, 2 * DEPTH - 1)) << 1;
    @(negedge clk);
    bus.load_start = 1'b0;
    chk("hold_in_load", 32'(bus.core_hold), 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            bus.load_valid = 1'b0;
            @(negedge clk);
          end
        end
        chk("ready_in_load", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_byte  = words[i][8*b +: 8];
        @(negedge clk);
      end
    end
    bus.load_valid = 1'b0;
    chk("done_pulse", 32'(bus.load_done), 32'd1);
    chk("done_hold", 32'(bus.core_hold), 32'd1);
    @(negedge clk);
    chk("done_cleared", 32'(bus.load_done), 32'd0);
    chk("hold_cleared", 32'(bus.core_hold), 32'd0);
    chk("ready_cleared", 32'(bus.load_ready), 32'd0);
    chk("held_fetch_nop", bus.fetch_data, NOP);
    for (int i = 0; i < n; i++) begin
      mem_m[i % DEPTH]   = words[i];
      known_m[i % DEPTH] = 1'b1;
    end
    last_d  = NOP;
    last_f  = 1'b0;
    last_ok = 1'b1;
  endtask

  logic [31:0] q [$];
  logic [31:0] a;
  int          n;

  initial begin
    reset          = 1'b1;
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_byte  = '0;
    last_d  = NOP;
    last_f  = 1'b0;
    last_ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fetch_data", bus.fetch_data, NOP);
    chk("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_core_hold", 32'(bus.core_hold), 32'd0);
    reset = 1'b0;

    // Two-word boot image, then straddling and aligned fetches.
    q = '{32'h0010_0513, 32'h0020_0593};
    load_words(q, 1'b0);
    do_fetch(32'h0, "t1_fetch0");
    chk("t1_literal", bus.fetch_data, 32'h0010_0513);
    do_fetch(32'h2, "t2_fetch2");
    chk("t2_literal", bus.fetch_data, 32'h0593_0010);
    do_fetch(32'h4, "t2_fetch4");
    chk("t2_literal4", bus.fetch_data, 32'h0020_0593);
    stall_check(3);
    chk("t3_literal", bus.fetch_data, 32'h0020_0593);

    // Top-word wrap and out-of-range aliasing.
    q = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'hAAAA_BBBB};
    load_words(q, 1'b1);
    do_fetch(32'hE, "t4_wrap");
    chk("t4_literal", bus.fetch_data, 32'h2222_AAAA);
    do_fetch(32'h10, "t5_oor");
`ifdef IMEM_RANGE_CHECK_EN
    chk("t5_literal", bus.fetch_data, NOP);
    chk("t5_fault", 32'(bus.fetch_fault), 32'd1);
`else
    chk("t5_literal", bus.fetch_data, 32'h1111_2222);
    chk("t5_fault", 32'(bus.fetch_fault), 32'd0);
`endif

    // Zero-length load goes straight to the done pulse.
    @(negedge clk);
    bus.fetch_en   = 1'b0;
    bus.load_start = 1'b1;
    bus.load_len   = '0;
    @(negedge clk);
    bus.load_start = 1'b0;
    chk("len0_done", 32'(bus.load_done), 32'd1);
    chk("len0_hold", 32'(bus.core_hold), 32'd1);
    chk("len0_ready", 32'(bus.load_ready), 32'd0);
    @(negedge clk);
    chk("len0_done_clr", 32'(bus.load_done), 32'd0);
    chk("len0_hold_clr", 32'(bus.core_hold), 32'd0);

    // Reset after three bytes discards the partial word.
    bus.load_start = 1'b1;
    bus.load_len   = LEN_W'(1);
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.load_valid = 1'b1;
      bus.load_byte  = 8'($urandom);
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_ready", 32'(bus.load_ready), 32'd0);
    chk("t6_hold", 32'(bus.core_hold), 32'd0);
    chk("t6_data_nop", bus.fetch_data, NOP);
    @(negedge clk);
    reset = 1'b0;
    do_fetch(32'h0, "t6_word0_kept");
    chk("t6_literal", bus.fetch_data, 32'h1111_2222);
    q = '{32'hCAFE_F00D};
    load_words(q, 1'b0);
    do_fetch(32'h0, "t6_reload");
    chk("t6_reload_literal", bus.fetch_data, 32'hCAFE_F00D);

    // Randomized loads (some wrap past the top) followed by random fetches and stalls.
    for (int it = 0; it < 8; it++) begin
      q.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) q.push_back($urandom);
      load_words(q, 1'b1);
      for (int f = 0; f < 10; f++) begin
        if ($urandom_range(0, 3) == 0) a = $urandom;
        else a = (32'($urandom_range(0, 2 * DEPTH - 1)) << 1) | 32'($urandom_range(0, 1));
        do_fetch(a, "rand_fetch");
        if ($urandom_range(0, 3) == 0) stall_check($urandom_range(1, 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
